// File: rtl/dram_cmd_arbiter_if.sv
// Purpose: requester-side bundle for dram_cmd_arbiter (two single-beat ports).
// Latency: n/a, this file only groups wires.
// Backpressure: a requester holds req with its fields until its gnt pulses.
// Ports: req/we/addr/wdata/wstrb per port in; gnt/done/rdata per port and busy out.
interface dram_cmd_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [3:0]  wstrb0;
  logic [3:0]  wstrb1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        busy;

  // Requester side (CPU path, DMA engine, or a testbench).
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy
  );
endinterface

// File: rtl/dram_cmd_arbiter.sv
// Purpose: two-port round-robin closed-page DRAM scheduler (ACT -> RD/WR -> PRE).
// Latency: grant t -> ACT t+1, CAS t+1+TRCD; read done one cycle after VALID, write done at CAS+TWR.
// Backpressure: gnt only in IDLE, so requests made while busy simply wait, held by the requester.
// Ports: ACLK, ARESETn (sync, active-low); host = requester bundle (slave modport);
//        CSn/RASn/CASn/WEn/A/D = DRAM command pins; Q/VALID = DRAM read return.
module dram_cmd_arbiter #(
  parameter int TRCD = 5,
  parameter int TWR  = 5,
  parameter int TRP  = 5
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  dram_cmd_arbiter_if.slave   host,
  output logic                CSn,
  output logic                RASn,
  output logic                CASn,
  output logic [3:0]          WEn,
  output logic [10:0]         A,
  output logic [31:0]         D,
  input  logic [31:0]         Q,
  input  logic                VALID
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD, S_CAS, S_RWAIT, S_WRWAIT, S_PRE, S_RP
  } state_t;

  // Captured transaction; only the row/column bits of the address are kept.
  typedef struct packed {
    logic        port;
    logic        we;
    logic [10:0] row;
    logic [9:0]  col;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  // Wait states are entered one cycle after the command, and the counter
  // starts at 0 on entry, so a gap of N cycles ends at count N-2.
  localparam logic [3:0] RCD_END = 4'(TRCD - 2);
  localparam logic [3:0] WR_END  = 4'(TWR - 2);
  localparam logic [3:0] RP_END  = 4'(TRP - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_gnt;   // 1 = port 1 was granted most recently
  cmd_t       cmd, cmd_nxt;
  logic       in_idle;

  assign in_idle   = ARESETn && (state == S_IDLE);
  // Tie goes to the port that did not win last time; a lone requester always wins.
  assign host.gnt0 = in_idle && host.req0 && (!host.req1 || last_gnt);
  assign host.gnt1 = in_idle && host.req1 && (!host.req0 || !last_gnt);
  assign host.busy = (state != S_IDLE);

  always_comb begin
    cmd_nxt       = '0;
    cmd_nxt.port  = host.gnt1;
    cmd_nxt.we    = host.gnt1 ? host.we1 : host.we0;
    cmd_nxt.row   = host.gnt1 ? host.addr1[22:12] : host.addr0[22:12];
    cmd_nxt.col   = host.gnt1 ? host.addr1[11:2]  : host.addr0[11:2];
    cmd_nxt.wdata = host.gnt1 ? host.wdata1 : host.wdata0;
    cmd_nxt.wstrb = host.gnt1 ? host.wstrb1 : host.wstrb0;
  end

  // Address bits outside row/column are don't-care for this device.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{host.addr0[31:23], host.addr0[1:0],
                              host.addr1[31:23], host.addr1[1:0]};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      last_gnt    <= 1'b1;
      cmd         <= '0;
      host.done0  <= 1'b0;
      host.done1  <= 1'b0;
      host.rdata0 <= 32'd0;
      host.rdata1 <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
      if (host.gnt0 || host.gnt1) begin
        last_gnt <= host.gnt1;
        cmd      <= cmd_nxt;
      end
      // done is registered so it lines up with the PRE command cycle.
      host.done0 <= (state_nxt == S_PRE) && !cmd.port;
      host.done1 <= (state_nxt == S_PRE) &&  cmd.port;
      if (state == S_RWAIT && VALID) begin
        if (cmd.port) host.rdata1 <= Q;
        else          host.rdata0 <= Q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (host.gnt0 || host.gnt1) state_nxt = S_ACT;
      S_ACT:    state_nxt = S_RCD;
      S_RCD:    if (cnt == RCD_END) state_nxt = S_CAS;
      S_CAS:    state_nxt = cmd.we ? S_WRWAIT : S_RWAIT;
      S_RWAIT:  if (VALID) state_nxt = S_PRE;
      S_WRWAIT: if (cnt == WR_END) state_nxt = S_PRE;
      S_PRE:    state_nxt = S_RP;
      S_RP:     if (cnt == RP_END) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Command pins decode straight from the state register and captured command.
  always_comb begin
    CSn  = 1'b1;
    RASn = 1'b1;
    CASn = 1'b1;
    WEn  = 4'hF;
    A    = 11'd0;
    D    = 32'd0;
    case (state)
      S_IDLE: ;
      S_ACT: begin
        CSn  = 1'b0;
        RASn = 1'b0;
        A    = cmd.row;
      end
      S_CAS: begin
        CSn  = 1'b0;
        CASn = 1'b0;
        A    = {1'b0, cmd.col};
        if (cmd.we) begin
          WEn = ~cmd.wstrb;
          D   = cmd.wdata;
        end
      end
      S_WRWAIT: begin
        CSn = 1'b0;
        D   = cmd.wdata;
      end
      S_PRE: begin
        CSn  = 1'b0;
        RASn = 1'b0;
        WEn  = 4'h0;
        A    = cmd.row;
      end
      default: CSn = 1'b0;   // RCD, RWAIT, RP: NOP
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Purpose: directed self-checking bench for dram_cmd_arbiter (default and short-timing builds).
// Latency: checks exact cycle placement of ACT/CAS/PRE/done/IDLE against hand-computed offsets.
// Backpressure: exercises waiting requesters, ties, lone requesters and reset mid-read.
module tb_dram_cmd_arbiter;
  logic ACLK;
  logic ARESETn;

  dram_cmd_arbiter_if ifa();
  dram_cmd_arbiter_if ifb();

  logic        a_CSn, a_RASn, a_CASn, b_CSn, b_RASn, b_CASn;
  logic [3:0]  a_WEn, b_WEn;
  logic [10:0] a_A, b_A;
  logic [31:0] a_D, b_D;
  logic [31:0] a_Q, b_Q;
  logic        a_VALID, b_VALID;

  dram_cmd_arbiter dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn), .host(ifa.slave),
    .CSn(a_CSn), .RASn(a_RASn), .CASn(a_CASn), .WEn(a_WEn), .A(a_A), .D(a_D),
    .Q(a_Q), .VALID(a_VALID)
  );

  dram_cmd_arbiter #(.TRCD(2), .TWR(3), .TRP(2)) dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn), .host(ifb.slave),
    .CSn(b_CSn), .RASn(b_RASn), .CASn(b_CASn), .WEn(b_WEn), .A(b_A), .D(b_D),
    .Q(b_Q), .VALID(b_VALID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic get_gnt(input int p);
    return (p != 0) ? ifa.gnt1 : ifa.gnt0;
  endfunction
  function automatic logic get_done(input int p);
    return (p != 0) ? ifa.done1 : ifa.done0;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p != 0) ? ifa.rdata1 : ifa.rdata0;
  endfunction

  task automatic set_req(input int p, input logic v);
    if (p != 0) ifa.req1 = v;
    else        ifa.req0 = v;
  endtask

  // Called in the IDLE cycle where port p must be granted; returns in the next IDLE cycle.
  task automatic run_read(input int p, input logic [31:0] q, input logic [31:0] exp_other,
                          input logic release_req);
    chkb("rd_gnt_win", get_gnt(p), 1'b1);
    chkb("rd_gnt_lose", get_gnt(1 - p), 1'b0);
    tick();                                   // t+1: ACT
    if (release_req) set_req(p, 1'b0);
    chkb("rd_act_ras", a_RASn, 1'b0);
    chkb("rd_busy", ifa.busy, 1'b1);
    ticks(4);                                 // t+5: still RCD
    chk("rd_no_gnt_busy", {30'd0, ifa.gnt1, ifa.gnt0}, 32'd0);
    tick();                                   // t+6: CAS
    chkb("rd_cas", a_CASn, 1'b0);
    ticks(3);                                 // t+9: VALID
    a_VALID = 1'b1;
    a_Q     = q;
    tick();                                   // t+10: PRE/done
    a_VALID = 1'b0;
    a_Q     = 32'd0;
    chkb("rd_done", get_done(p), 1'b1);
    chkb("rd_done_other", get_done(1 - p), 1'b0);
    chk("rd_rdata", get_rdata(p), q);
    chk("rd_rdata_other", get_rdata(1 - p), exp_other);
    ticks(5);                                 // t+15: IDLE
    chkb("rd_idle", ifa.busy, 1'b0);
  endtask

  task automatic run_write(input int p, input logic [3:0] exp_wen, input logic [31:0] exp_d,
                           input logic [31:0] exp_other, input logic release_req);
    chkb("wr_gnt_win", get_gnt(p), 1'b1);
    chkb("wr_gnt_lose", get_gnt(1 - p), 1'b0);
    tick();                                   // t+1: ACT
    if (release_req) set_req(p, 1'b0);
    chkb("wr_act_ras", a_RASn, 1'b0);
    ticks(5);                                 // t+6: CAS
    chkb("wr_cas", a_CASn, 1'b0);
    chk("wr_wen", 32'(a_WEn), 32'(exp_wen));
    chk("wr_d", a_D, exp_d);
    tick();                                   // t+7: WRWAIT, D held
    chkb("wr_wait_cas", a_CASn, 1'b1);
    chk("wr_d_held", a_D, exp_d);
    ticks(3);                                 // t+10: not yet done
    chkb("wr_done_early", get_done(p), 1'b0);
    tick();                                   // t+11: PRE/done
    chkb("wr_done", get_done(p), 1'b1);
    chkb("wr_done_other", get_done(1 - p), 1'b0);
    chk("wr_pre_wen", 32'(a_WEn), 32'h0);
    chk("wr_rdata_other", get_rdata(1 - p), exp_other);
    ticks(4);                                 // t+15: RP
    chkb("wr_busy_rp", ifa.busy, 1'b1);
    tick();                                   // t+16: IDLE
    chkb("wr_idle", ifa.busy, 1'b0);
  endtask

  initial begin
    ARESETn = 1'b0;
    ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0;
    ifa.addr0 = 0; ifa.addr1 = 0; ifa.wdata0 = 0; ifa.wdata1 = 0;
    ifa.wstrb0 = 0; ifa.wstrb1 = 0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.we0 = 0; ifb.we1 = 0;
    ifb.addr0 = 0; ifb.addr1 = 0; ifb.wdata0 = 0; ifb.wdata1 = 0;
    ifb.wstrb0 = 0; ifb.wstrb1 = 0;
    a_Q = 0; a_VALID = 0; b_Q = 0; b_VALID = 0;

    // Reset state
    ticks(2);
    chkb("rst_busy", ifa.busy, 1'b0);
    chk("rst_pins", {28'd0, a_CSn, a_RASn, a_CASn, 1'b0}, {28'd0, 4'b1110});
    chk("rst_wen", 32'(a_WEn), 32'hF);
    chk("rst_a", 32'(a_A), 32'h0);
    chk("rst_d", a_D, 32'h0);
    chk("rst_done", {30'd0, ifa.done1, ifa.done0}, 32'd0);
    chk("rst_rdata0", ifa.rdata0, 32'd0);
    chk("rst_rdata1", ifa.rdata1, 32'd0);
    ARESETn = 1'b1;
    tick();

    // Port 0 read, addr 0x0040_1234, VALID 3 cycles after CAS
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 32'h0040_1234;
    #1;
    chkb("t1_gnt0", ifa.gnt0, 1'b1);
    chkb("t1_gnt1", ifa.gnt1, 1'b0);
    tick();                                   // t+1
    ifa.req0 = 0;
    chk("t1_act_pins", {29'd0, a_CSn, a_RASn, a_CASn}, 32'b001);
    chk("t1_act_a", 32'(a_A), 32'h401);
    ticks(4);                                 // t+5
    chk("t1_rcd_pins", {29'd0, a_CSn, a_RASn, a_CASn}, 32'b011);
    tick();                                   // t+6
    chk("t1_cas_pins", {29'd0, a_CSn, a_RASn, a_CASn}, 32'b010);
    chk("t1_cas_a", 32'(a_A), 32'h08D);
    chk("t1_cas_wen", 32'(a_WEn), 32'hF);
    ticks(3);                                 // t+9
    chkb("t1_done_early", ifa.done0, 1'b0);
    a_VALID = 1; a_Q = 32'hDEAD_BEEF;
    tick();                                   // t+10
    a_VALID = 0; a_Q = 0;
    chkb("t1_done0", ifa.done0, 1'b1);
    chkb("t1_done1", ifa.done1, 1'b0);
    chk("t1_rdata0", ifa.rdata0, 32'hDEAD_BEEF);
    chk("t1_pre_pins", {29'd0, a_CSn, a_RASn, a_CASn}, 32'b001);
    chk("t1_pre_wen", 32'(a_WEn), 32'h0);
    chk("t1_pre_a", 32'(a_A), 32'h401);
    tick();                                   // t+11
    chkb("t1_done_pulse", ifa.done0, 1'b0);
    chk("t1_rdata_held", ifa.rdata0, 32'hDEAD_BEEF);
    ticks(3);                                 // t+14
    chkb("t1_busy_rp", ifa.busy, 1'b1);
    tick();                                   // t+15
    chkb("t1_idle", ifa.busy, 1'b0);

    // Port 1 write, strobes 0011
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 32'h0012_3008;
    ifa.wdata1 = 32'h1122_3344; ifa.wstrb1 = 4'b0011;
    #1;
    run_write(1, 4'b1100, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1);

    // Both held: order 0, 1, 0 (pointer last = 1 after the port 1 write)
    ifa.we0 = 0; ifa.we1 = 0;
    ifa.addr0 = 32'h0000_1000; ifa.addr1 = 32'h0000_2000;
    ifa.req0 = 1; ifa.req1 = 1;
    #1;
    run_read(0, 32'hA1A1_0001, 32'h0000_0000, 1'b0);
    run_read(1, 32'hB2B2_0002, 32'hA1A1_0001, 1'b0);
    run_read(0, 32'hC3C3_0003, 32'hB2B2_0002, 1'b1);

    // Lone port 1 requester, twice in a row
    ifa.we1 = 1; ifa.wdata1 = 32'hCAFE_F00D; ifa.wstrb1 = 4'b1111;
    #1;
    run_write(1, 4'b0000, 32'hCAFE_F00D, 32'hC3C3_0003, 1'b0);
    run_write(1, 4'b0000, 32'hCAFE_F00D, 32'hC3C3_0003, 1'b1);

    // Reset in RWAIT: port 0 read, reset at t+7
    ifa.we0 = 0; ifa.req0 = 1;
    #1;
    chkb("t5_gnt0", ifa.gnt0, 1'b1);
    tick();                                   // t+1
    ifa.req0 = 0;
    ticks(6);                                 // t+7: RWAIT
    chkb("t5_rwait_busy", ifa.busy, 1'b1);
    ARESETn = 0;
    tick();                                   // t+8
    ARESETn = 1;
    chkb("t5_rst_busy", ifa.busy, 1'b0);
    chk("t5_rst_pins", {29'd0, a_CSn, a_RASn, a_CASn}, 32'b111);
    chk("t5_rst_wen", 32'(a_WEn), 32'hF);
    chkb("t5_rst_done0", ifa.done0, 1'b0);
    chk("t5_rst_rdata0", ifa.rdata0, 32'd0);
    chk("t5_rst_rdata1", ifa.rdata1, 32'd0);
    a_VALID = 1; a_Q = 32'h7777_7777;
    tick();                                   // stray VALID in IDLE
    a_VALID = 0; a_Q = 0;
    chkb("t5_stray_done", ifa.done0, 1'b0);
    chk("t5_stray_rdata", ifa.rdata0, 32'd0);
    chkb("t5_stray_busy", ifa.busy, 1'b0);
    // Tie right after reset: pointer back to 1, so port 0 wins
    ifa.req0 = 1; ifa.req1 = 1; ifa.we1 = 0;
    #1;
    chkb("t5_tie_gnt0", ifa.gnt0, 1'b1);
    chkb("t5_tie_gnt1", ifa.gnt1, 1'b0);
    ifa.req1 = 0;
    #1;
    run_read(0, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1);

    // Short-timing build: TRCD=2, TWR=3, TRP=2, write
    ifb.req0 = 1; ifb.we0 = 1; ifb.addr0 = 32'h0000_5004;
    ifb.wdata0 = 32'h0BAD_F00D; ifb.wstrb0 = 4'b1010;
    #1;
    chkb("t6_gnt0", ifb.gnt0, 1'b1);
    tick();                                   // t+1
    ifb.req0 = 0;
    chkb("t6_act", b_RASn, 1'b0);
    tick();                                   // t+2
    chkb("t6_rcd", b_CASn, 1'b1);
    tick();                                   // t+3
    chkb("t6_cas", b_CASn, 1'b0);
    chk("t6_cas_wen", 32'(b_WEn), 32'h5);
    chk("t6_cas_d", b_D, 32'h0BAD_F00D);
    ticks(2);                                 // t+5
    chkb("t6_done_early", ifb.done0, 1'b0);
    tick();                                   // t+6
    chkb("t6_done", ifb.done0, 1'b1);
    chkb("t6_pre", b_RASn, 1'b0);
    tick();                                   // t+7
    chkb("t6_busy_rp", ifb.busy, 1'b1);
    tick();                                   // t+8
    chkb("t6_idle", ifb.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_cmd_arbiter.md
# dram_cmd_arbiter

Two-port closed-page DRAM command scheduler that shares one DRAM device pin interface (CSn/RASn/CASn/WEn/A/D/Q/VALID) between two single-beat requesters, e.g. the CPU-side AXI slave path (port 0) and a DMA engine (port 1). It arbitrates round-robin, sequences ACTIVATE → column READ/WRITE → PRECHARGE with parameterised row/column timing, and returns a one-cycle completion pulse carrying the read data to the winning port.

## Interface
- TRCD, 5, cycles from ACT command cycle to CAS command cycle (legal 2..15)
- TWR, 5, cycles from write CAS cycle to PRE command cycle (legal 2..15)
- TRP, 5, cycles from PRE command cycle to return to IDLE (legal 2..15)
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request; held with its fields until matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address; row = addr[22:12], col = addr[11:2]
- wdata0 / wdata1  in  32  write data
- wstrb0 / wstrb1  in  4  byte enables, active-high
- gnt0 / gnt1  out  1  combinational accept, asserted only in IDLE
- done0 / done1  out  1  one-cycle completion pulse, registered
- rdata0 / rdata1  out  32  read data, valid with done, held until the next read completion on that port
- busy  out  1  high whenever state ≠ IDLE
- CSn, RASn, CASn  out  1 each  DRAM commands, active-low
- WEn  out  4  DRAM byte write enables, active-low
- A  out  11  DRAM row/column address
- D  out  32  DRAM write data
- Q  in  32  DRAM read data
- VALID  in  1  Q valid strobe from DRAM

## Operation
- States: IDLE, ACT, RCD, CAS, RWAIT, WRWAIT, PRE, RP. 4-bit delay counter cleared on every state entry.
- IDLE: CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0. If any req: grant per arbitration, capture we/addr/wdata/wstrb and port index, go to ACT.
- Arbitration: only one requesting → that port. Both → the port not granted last time. Last-granted pointer updates on every grant; reset value 1, so port 0 wins the first tie.
- ACT (1 cycle): CSn=0, RASn=0, A=row → RCD.
- RCD: NOP (CSn=0, RASn=CASn=1, WEn=4'hF); exits so that CAS falls exactly TRCD cycles after ACT.
- CAS (1 cycle): CSn=0, CASn=0, A={1'b0,col}. Write: WEn=~wstrb, D=wdata → WRWAIT. Read: WEn=4'hF → RWAIT.
- RWAIT: NOP; when VALID=1, capture Q into the captured port's rdata → PRE. VALID is ignored in every other state. There is no timeout.
- WRWAIT: NOP with D held; exits so that PRE falls exactly TWR cycles after CAS.
- PRE (1 cycle): CSn=0, RASn=0, WEn=4'h0, A=row. done for the captured port is high in this cycle, for both reads and writes → RP.
- RP: NOP; IDLE is entered exactly TRP cycles after PRE.
- gnt, done and rdata of the non-captured port are never disturbed.

## Timing
- Reset (any state, including mid-transaction): next cycle state=IDLE, all commands deasserted as in IDLE, gnt=0, done=0, rdata=0, busy=0, pointer=1. A transaction interrupted by reset never produces done.
- Grant at cycle t (IDLE): ACT at t+1, CAS at t+1+TRCD.
- Read: VALID at cycle v (≥ CAS+1) → PRE/done at v+1, IDLE at v+1+TRP.
- Write: PRE/done at CAS+TWR, IDLE at CAS+TWR+TRP.
- With defaults, a write granted at t0 gives ACT t0+1, CAS t0+6, PRE/done t0+11, IDLE t0+16. The earliest next gnt is t0+16 and the earliest next ACT is t0+17.
- A request arriving while busy waits; gnt never asserts outside IDLE. req deasserted before gnt withdraws the request without side effects.

## Test plan
- Port 0 read, addr=0x0040_1234, DRAM returns VALID 3 cycles after CAS with Q=0xDEADBEEF → ACT with A=0x401 at t+1, CAS with A=0x08D at t+6, done0 and rdata0=0xDEADBEEF at t+10, IDLE at t+15.
- Port 1 write, wdata=0x1122_3344, wstrb=4'b0011 → CAS at t+6 with WEn=4'b1100 and D=0x11223344, done1 at t+11, busy low at t+16.
- req0 and req1 asserted together and held across three transactions → grant order 0, 1, 0; each done goes only to the granted port; the other port's rdata is unchanged.
- Only req1 asserted repeatedly → port 1 is granted every time; the pointer does not block a lone requester.
- ARESETn low for 1 cycle during RWAIT → next cycle IDLE with all commands inactive; no done; a later VALID pulse is ignored; a fresh req0 then proceeds normally.
- TRCD=2, TWR=3, TRP=2 build → CAS at t+3, write PRE at t+6, IDLE at t+8.
